// File: rtl/otter_wb_pkg.sv
// Shared types and constants for the OTTER MEM/WB writeback stage.
//   wb_sel_t  - writeback source select (ALU, LOAD, PC+4, CSR)
//   F3_*      - load funct3 encodings
//   wb_reg_t  - contents of the MEM/WB pipeline register
package otter_wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_CSR  = 2'd3
  } wb_sel_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        rf_we;
    wb_sel_t     wb_sel;
    logic [2:0]  funct3;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] csr;
    logic [31:0] dmem;
  } wb_reg_t;

endpackage

// File: rtl/otter_load_align.sv
// Load data alignment and misalignment detection (purely combinational).
//   funct3_i   - load type (LB/LH/LW/LBU/LHU; any other code behaves as LW)
//   addr_i     - low two bits of the load address
//   word_i     - raw 32-bit data-memory word
//   data_o     - aligned, sign/zero-extended load value
//   misalign_o - access is not naturally aligned for its size
module otter_load_align
  import otter_wb_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    byte_sel   = word_i[7:0];
    half_sel   = addr_i[1] ? word_i[31:16] : word_i[15:0];
    data_o     = word_i;
    misalign_o = (addr_i != 2'b00);

    case (addr_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase

    case (funct3_i)
      F3_LB: begin
        data_o     = {{24{byte_sel[7]}}, byte_sel};
        misalign_o = 1'b0;
      end
      F3_LBU: begin
        data_o     = {24'd0, byte_sel};
        misalign_o = 1'b0;
      end
      F3_LH: begin
        data_o     = {{16{half_sel[15]}}, half_sel};
        misalign_o = addr_i[0];
      end
      F3_LHU: begin
        data_o     = {16'd0, half_sel};
        misalign_o = addr_i[0];
      end
      default: begin
        // LW and undefined codes: whole word, must be word aligned.
        data_o     = word_i;
        misalign_o = (addr_i != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/otter_wb_stage.sv
// OTTER MEM/WB pipeline stage. Registers the retiring instruction, aligns
// load data, selects the writeback source and drives the register-file
// write port plus an identical forwarding path. Counts retired instructions.
//   CLK, RST            - clock, synchronous active-high reset
//   STALL, FLUSH        - hold the WB register / capture a bubble
//   M_*                 - MEM-stage instruction fields
//   RF_EN/RF_WA/RF_WD   - register-file write port
//   FWD_VALID/RD/DATA   - forwarding copy of the write port
//   LD_MISALIGN         - retiring load is misaligned (write suppressed)
//   INSTRET             - retired-instruction counter
// Only XLEN = 32 is supported.
module otter_wb_stage
  import otter_wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             STALL,
  input  logic             FLUSH,
  input  logic             M_VALID,
  input  logic [4:0]       M_RD,
  input  logic             M_RF_WE,
  input  logic [1:0]       M_WB_SEL,
  input  logic [2:0]       M_FUNCT3,
  input  logic [XLEN-1:0]  M_ALU,
  input  logic [XLEN-1:0]  M_PC,
  input  logic [XLEN-1:0]  M_CSR,
  input  logic [XLEN-1:0]  M_DMEM,
  output logic             RF_EN,
  output logic [4:0]       RF_WA,
  output logic [XLEN-1:0]  RF_WD,
  output logic             FWD_VALID,
  output logic [4:0]       FWD_RD,
  output logic [XLEN-1:0]  FWD_DATA,
  output logic             LD_MISALIGN,
  output logic [CNT_W-1:0] INSTRET
);

  wb_reg_t          w_q, w_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [31:0] load_data;
  logic        align_misalign;
  logic        misalign;
  logic [31:0] wb_data;
  logic        wr_en;

  // Capture logic: STALL holds everything (it outranks FLUSH); FLUSH only
  // kills the valid bit, the payload fields still follow M_*.
  always_comb begin
    w_d = w_q;
    if (!STALL) begin
      w_d.valid  = M_VALID & ~FLUSH;
      w_d.rd     = M_RD;
      w_d.rf_we  = M_RF_WE;
      w_d.wb_sel = wb_sel_t'(M_WB_SEL);
      w_d.funct3 = M_FUNCT3;
      w_d.alu    = M_ALU;
      w_d.pc     = M_PC;
      w_d.csr    = M_CSR;
      w_d.dmem   = M_DMEM;
    end
  end

  // An instruction retires on the edge that moves it out of WB, i.e. any
  // unstalled edge while it is valid. Misaligned loads still retire.
  always_comb begin
    instret_d = instret_q;
    if (w_q.valid && !STALL) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (RST) begin
      // NOTE: the whole payload is cleared, not just valid, so the write
      // port shows address and data zero right after reset.
      w_q       <= '0;
      instret_q <= '0;
    end else begin
      w_q       <= w_d;
      instret_q <= instret_d;
    end
  end

  otter_load_align u_load_align (
    .funct3_i   (w_q.funct3),
    .addr_i     (w_q.alu[1:0]),
    .word_i     (w_q.dmem),
    .data_o     (load_data),
    .misalign_o (align_misalign)
  );

  assign misalign = w_q.valid && (w_q.wb_sel == WB_LOAD) && align_misalign;

  always_comb begin
    wb_data = w_q.alu;
    case (w_q.wb_sel)
      WB_ALU:  wb_data = w_q.alu;
      WB_LOAD: wb_data = load_data;
      WB_PC4:  wb_data = w_q.pc + 32'd4;  // wraps: 0xFFFFFFFC -> 0
      WB_CSR:  wb_data = w_q.csr;
      default: wb_data = w_q.alu;
    endcase
  end

  // x0 is hardwired zero: never written, never forwarded.
  assign wr_en = w_q.valid && w_q.rf_we && (w_q.rd != 5'd0) && !misalign;

  assign RF_EN       = wr_en;
  assign RF_WA       = w_q.rd;
  assign RF_WD       = wb_data;
  assign FWD_VALID   = wr_en;
  assign FWD_RD      = w_q.rd;
  assign FWD_DATA    = wb_data;
  assign LD_MISALIGN = misalign;
  assign INSTRET     = instret_q;

endmodule

// File: tb/tb_otter_wb_stage.sv
module tb_otter_wb_stage;

  logic        CLK = 1'b0;
  logic        RST, STALL, FLUSH, M_VALID, M_RF_WE;
  logic [4:0]  M_RD;
  logic [1:0]  M_WB_SEL;
  logic [2:0]  M_FUNCT3;
  logic [31:0] M_ALU, M_PC, M_CSR, M_DMEM;
  logic        RF_EN, FWD_VALID, LD_MISALIGN;
  logic [4:0]  RF_WA, FWD_RD;
  logic [31:0] RF_WD, FWD_DATA, INSTRET;

  int total = 0;
  int bad   = 0;
  int unsigned exp_cnt = 0;

  otter_wb_stage #(.XLEN(32), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
    .M_VALID(M_VALID), .M_RD(M_RD), .M_RF_WE(M_RF_WE), .M_WB_SEL(M_WB_SEL),
    .M_FUNCT3(M_FUNCT3), .M_ALU(M_ALU), .M_PC(M_PC), .M_CSR(M_CSR),
    .M_DMEM(M_DMEM), .RF_EN(RF_EN), .RF_WA(RF_WA), .RF_WD(RF_WD),
    .FWD_VALID(FWD_VALID), .FWD_RD(FWD_RD), .FWD_DATA(FWD_DATA),
    .LD_MISALIGN(LD_MISALIGN), .INSTRET(INSTRET)
  );

  always #5 CLK = ~CLK;

  // Outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                       input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc,
                       input logic [31:0] csr, input logic [31:0] dmem);
    M_VALID = v; M_RD = rd; M_RF_WE = we; M_WB_SEL = sel; M_FUNCT3 = f3;
    M_ALU = alu; M_PC = pc; M_CSR = csr; M_DMEM = dmem;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    drive(1'b1, 5'd3, 1'b1, 2'd0, 3'd0, 32'h33, 32'h0, 32'h0, 32'h0);
    tick(); tick();
    total++; if (INSTRET !== 32'd1) begin bad++; $display("FAIL pre_reset_instret: got %0d want 1", INSTRET); end
    RST = 1'b1;
    tick();
    total++; if (RF_EN !== 1'b0) begin bad++; $display("FAIL reset_rf_en: got %b want 0", RF_EN); end
    total++; if (FWD_VALID !== 1'b0) begin bad++; $display("FAIL reset_fwd_valid: got %b want 0", FWD_VALID); end
    total++; if (INSTRET !== 32'd0) begin bad++; $display("FAIL reset_instret: got %0d want 0", INSTRET); end
    total++; if (LD_MISALIGN !== 1'b0) begin bad++; $display("FAIL reset_misalign: got %b want 0", LD_MISALIGN); end
    total++; if (RF_WA !== 5'd0 || RF_WD !== 32'd0) begin bad++; $display("FAIL reset_wa_wd: got %0d/%h want 0/0", RF_WA, RF_WD); end
    RST = 1'b0;
    idle();
    tick();
    exp_cnt = 0;
  endtask

  task automatic test_alu();
    drive(1'b1, 5'd5, 1'b1, 2'd0, 3'd0, 32'h1234, 32'h40, 32'h0, 32'h0);
    tick();
    total++; if (RF_EN !== 1'b1) begin bad++; $display("FAIL alu_en: got %b want 1", RF_EN); end
    total++; if (RF_WA !== 5'd5) begin bad++; $display("FAIL alu_wa: got %0d want 5", RF_WA); end
    total++; if (RF_WD !== 32'h1234) begin bad++; $display("FAIL alu_wd: got %h want 00001234", RF_WD); end
    total++; if (FWD_VALID !== 1'b1 || FWD_RD !== 5'd5 || FWD_DATA !== 32'h1234) begin
      bad++; $display("FAIL alu_fwd: got %b/%0d/%h want 1/5/00001234", FWD_VALID, FWD_RD, FWD_DATA); end
    total++; if (INSTRET !== exp_cnt) begin bad++; $display("FAIL alu_instret_before: got %0d want %0d", INSTRET, exp_cnt); end
    idle();
    tick();
    exp_cnt += 1;
    total++; if (INSTRET !== exp_cnt) begin bad++; $display("FAIL alu_instret_after: got %0d want %0d", INSTRET, exp_cnt); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  ad  [5] = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] exp [5] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF,
                             32'h00007F01, 32'h80FF7F01};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd7, 1'b1, 2'd1, f3[i], {30'h04000000, ad[i]}, 32'h0,
            32'h0, 32'h80FF7F01);
      tick();
      total++; if (RF_WD !== exp[i]) begin bad++; $display("FAIL load%0d_wd: got %h want %h", i, RF_WD, exp[i]); end
      total++; if (RF_EN !== 1'b1 || LD_MISALIGN !== 1'b0) begin
        bad++; $display("FAIL load%0d_en: got en=%b mis=%b want en=1 mis=0", i, RF_EN, LD_MISALIGN); end
    end
    idle();
    tick();
    exp_cnt += 5;
    total++; if (INSTRET !== exp_cnt) begin bad++; $display("FAIL load_instret: got %0d want %0d", INSTRET, exp_cnt); end
  endtask

  task automatic test_misalign();
    drive(1'b1, 5'd8, 1'b1, 2'd1, 3'b010, 32'h00000102, 32'h0, 32'h0, 32'h11223344);
    tick();
    total++; if (LD_MISALIGN !== 1'b1 || RF_EN !== 1'b0 || FWD_VALID !== 1'b0) begin
      bad++; $display("FAIL mis_lw: got mis=%b en=%b fwd=%b want 1/0/0", LD_MISALIGN, RF_EN, FWD_VALID); end
    drive(1'b1, 5'd8, 1'b1, 2'd1, 3'b001, 32'h00000101, 32'h0, 32'h0, 32'h11223344);
    tick();
    total++; if (LD_MISALIGN !== 1'b1 || RF_EN !== 1'b0) begin
      bad++; $display("FAIL mis_lh: got mis=%b en=%b want 1/0", LD_MISALIGN, RF_EN); end
    // Odd address on a non-load is not a misalignment.
    drive(1'b1, 5'd4, 1'b1, 2'd0, 3'b010, 32'h00000003, 32'h0, 32'h0, 32'h0);
    tick();
    total++; if (LD_MISALIGN !== 1'b0 || RF_EN !== 1'b1 || RF_WD !== 32'h3) begin
      bad++; $display("FAIL mis_alu_odd: got mis=%b en=%b wd=%h want 0/1/00000003", LD_MISALIGN, RF_EN, RF_WD); end
    idle();
    tick();
    exp_cnt += 3;
    total++; if (INSTRET !== exp_cnt) begin bad++; $display("FAIL mis_instret: got %0d want %0d", INSTRET, exp_cnt); end
  endtask

  task automatic test_x0_pc4();
    drive(1'b1, 5'd0, 1'b1, 2'd0, 3'd0, 32'h55, 32'h0, 32'h0, 32'h0);
    tick();
    total++; if (RF_EN !== 1'b0 || FWD_VALID !== 1'b0) begin
      bad++; $display("FAIL x0_en: got en=%b fwd=%b want 0/0", RF_EN, FWD_VALID); end
    total++; if (RF_WA !== 5'd0 || RF_WD !== 32'h55) begin
      bad++; $display("FAIL x0_wa_wd: got %0d/%h want 0/00000055", RF_WA, RF_WD); end
    drive(1'b1, 5'd1, 1'b1, 2'd2, 3'd0, 32'h0, 32'hFFFFFFFC, 32'h0, 32'h0);
    tick();
    total++; if (RF_EN !== 1'b1 || RF_WD !== 32'h0) begin
      bad++; $display("FAIL pc4_wrap: got en=%b wd=%h want 1/00000000", RF_EN, RF_WD); end
    drive(1'b1, 5'd2, 1'b1, 2'd2, 3'd0, 32'h0, 32'h00000100, 32'h0, 32'h0);
    tick();
    total++; if (RF_WD !== 32'h104) begin bad++; $display("FAIL pc4: got %h want 00000104", RF_WD); end
    drive(1'b1, 5'd31, 1'b1, 2'd3, 3'd0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0);
    tick();
    total++; if (RF_WD !== 32'hDEADBEEF || RF_WA !== 5'd31 || RF_EN !== 1'b1) begin
      bad++; $display("FAIL csr: got en=%b wa=%0d wd=%h want 1/31/deadbeef", RF_EN, RF_WA, RF_WD); end
    idle();
    tick();
    exp_cnt += 4;
    total++; if (INSTRET !== exp_cnt) begin bad++; $display("FAIL x0pc4_instret: got %0d want %0d", INSTRET, exp_cnt); end
  endtask

  task automatic test_stall();
    drive(1'b1, 5'd9, 1'b1, 2'd0, 3'd0, 32'hA5A5, 32'h0, 32'h0, 32'h0);
    tick();
    STALL = 1'b1;
    drive(1'b1, 5'd10, 1'b1, 2'd0, 3'd0, 32'h1111, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (RF_EN !== 1'b1 || RF_WA !== 5'd9 || RF_WD !== 32'hA5A5) begin
        bad++; $display("FAIL stall%0d_hold: got %b/%0d/%h want 1/9/0000a5a5", i, RF_EN, RF_WA, RF_WD); end
      total++; if (INSTRET !== exp_cnt) begin bad++; $display("FAIL stall%0d_instret: got %0d want %0d", i, INSTRET, exp_cnt); end
    end
    STALL = 1'b0;
    idle();
    tick();
    exp_cnt += 1;
    total++; if (INSTRET !== exp_cnt) begin bad++; $display("FAIL stall_release_instret: got %0d want %0d", INSTRET, exp_cnt); end
  endtask

  task automatic test_flush();
    FLUSH = 1'b1;
    drive(1'b1, 5'd11, 1'b1, 2'd0, 3'd0, 32'h77, 32'h0, 32'h0, 32'h0);
    tick();
    total++; if (RF_EN !== 1'b0 || FWD_VALID !== 1'b0) begin
      bad++; $display("FAIL flush_en: got en=%b fwd=%b want 0/0", RF_EN, FWD_VALID); end
    FLUSH = 1'b0;
    idle();
    tick();
    total++; if (INSTRET !== exp_cnt) begin bad++; $display("FAIL flush_instret: got %0d want %0d", INSTRET, exp_cnt); end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 5'd12, 1'b1, 2'd0, 3'd0, 32'h99, 32'h0, 32'h0, 32'h0);
    tick();
    STALL = 1'b1; FLUSH = 1'b1;
    drive(1'b1, 5'd13, 1'b1, 2'd0, 3'd0, 32'h2222, 32'h0, 32'h0, 32'h0);
    tick();
    total++; if (RF_EN !== 1'b1 || RF_WA !== 5'd12 || RF_WD !== 32'h99) begin
      bad++; $display("FAIL stallflush_hold: got %b/%0d/%h want 1/12/00000099", RF_EN, RF_WA, RF_WD); end
    total++; if (INSTRET !== exp_cnt) begin bad++; $display("FAIL stallflush_instret: got %0d want %0d", INSTRET, exp_cnt); end
    STALL = 1'b0; FLUSH = 1'b0;
    idle();
    tick();
    exp_cnt += 1;
    total++; if (INSTRET !== exp_cnt) begin bad++; $display("FAIL stallflush_release: got %0d want %0d", INSTRET, exp_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 5'd14, 1'b1, 2'd0, 3'd0, 32'hBEEF, 32'h0, 32'h0, 32'h0);
    tick();
    STALL = 1'b1; RST = 1'b1;
    tick();
    total++; if (RF_EN !== 1'b0 || RF_WA !== 5'd0 || INSTRET !== 32'd0) begin
      bad++; $display("FAIL rst_stall: got en=%b wa=%0d cnt=%0d want 0/0/0", RF_EN, RF_WA, INSTRET); end
    STALL = 1'b0; RST = 1'b0;
    idle();
    tick();
    exp_cnt = 0;
    total++; if (RF_EN !== 1'b0 || INSTRET !== exp_cnt) begin
      bad++; $display("FAIL rst_stall_after: got en=%b cnt=%0d want 0/%0d", RF_EN, INSTRET, exp_cnt); end
  endtask

  initial begin
    RST = 1'b1; STALL = 1'b0; FLUSH = 1'b0;
    idle();
    tick(); tick();
    RST = 1'b0;
    test_reset();
    test_alu();
    test_loads();
    test_misalign();
    test_x0_pc4();
    test_stall();
    test_flush();
    test_stall_flush();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
